// File: rtl/mil_receiver_if.sv
// Downstream word push bus of the MIL-STD-1553 receiver.
// The master side drives a one-cycle strobe with the word type and the decoded word.
interface mil_receiver_if;
  logic        push_request;
  logic [1:0]  push_dataType;
  logic [15:0] push_dataWord;

  modport master (
    output push_request,
    output push_dataType,
    output push_dataWord
  );

  modport slave (
    input push_request,
    input push_dataType,
    input push_dataWord
  );
endinterface

// File: rtl/mil_receiver.sv
// MIL-STD-1553 Manchester-II receiver at 1 Mbit/s: sync detection, 16 data bits plus odd parity.
// Optional macro MIL_RX_ERROR_PUSH_EN: errored or aborted words are pushed as WERROR instead of dropped.
module mil_receiver #(
  parameter int HALFBIT_CLKS = 25,
  parameter int TOL_CLKS     = 6
) (
  input  logic           clk,
  input  logic           nRst,
  input  logic           RXin,
  input  logic           nRXin,
  input  logic           grant,
  output logic           busy,
  mil_receiver_if.master push
);

  localparam logic [1:0] WCOMMAND = 2'd0;
  localparam logic [1:0] WDATA    = 2'd2;
  localparam logic [1:0] WERROR   = 2'd3;

  localparam logic [7:0] SYNC_NOM_M1 = 8'(3 * HALFBIT_CLKS - 1);
  localparam logic [7:0] SYNC_MIN    = 8'(3 * HALFBIT_CLKS - TOL_CLKS);
  localparam logic [7:0] SYNC_MAX    = 8'(3 * HALFBIT_CLKS + TOL_CLKS);
  localparam logic [6:0] SAMP1       = 7'(HALFBIT_CLKS / 2);
  localparam logic [6:0] SAMP2       = 7'(HALFBIT_CLKS + HALFBIT_CLKS / 2);
  localparam logic [6:0] MID_LO      = 7'(HALFBIT_CLKS - TOL_CLKS);
  localparam logic [6:0] MID_HI      = 7'(HALFBIT_CLKS + TOL_CLKS);
  localparam logic [6:0] MID_NEXT    = 7'(HALFBIT_CLKS + 1);
  localparam logic [6:0] BIT_LAST    = 7'(2 * HALFBIT_CLKS - 1);
  localparam logic [4:0] LAST_IDX    = 5'd17;

`ifdef MIL_RX_ERROR_PUSH_EN
  localparam logic ERR_PUSH_EN = 1'b1;
`else
  localparam logic ERR_PUSH_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC1 = 3'd1,
    ST_SYNC2 = 3'd2,
    ST_BITS  = 3'd3,
    ST_CHECK = 3'd4
  } state_t;

  function automatic logic odd_parity_ok(input logic [15:0] data, input logic par);
    return ^{data, par};
  endfunction

  state_t      state_r, state_nxt_s;
  logic        rx_meta_r, rx_sync_r, nrx_meta_r, nrx_sync_r;
  logic        lvl_q_r, sync_lvl_r, half1_r, par_r;
  logic [7:0]  cnt_r;
  logic [6:0]  ph_r;
  logic [4:0]  bit_idx_r;
  logic [15:0] word_r;
  logic        req_r, busy_r;
  logic [1:0]  type_r;
  logic [15:0] dword_r;

  logic valid_s, lvl_s, sync_same_s, edge_s, run_in_win_s;
  logic man_err_s, bits_err_s, parity_ok_s;
  logic busy_s, push_good_s, push_err_s;

  // A differential pair with equal legs is the null (idle) state of the bus.
  assign valid_s      = rx_sync_r ^ nrx_sync_r;
  assign lvl_s        = rx_sync_r;
  assign sync_same_s  = (lvl_s == sync_lvl_r);
  assign edge_s       = (lvl_s != lvl_q_r);
  assign run_in_win_s = (cnt_r >= SYNC_MIN) && (cnt_r <= SYNC_MAX);
  assign man_err_s    = (ph_r == SAMP2) && (lvl_s == half1_r);
  assign bits_err_s   = !valid_s || man_err_s;
  assign parity_ok_s  = odd_parity_ok(word_r, par_r);

  // Two-flop synchronizer on both line legs
  always_ff @(posedge clk) begin
    if (!nRst) begin
      rx_meta_r  <= 1'b0;
      rx_sync_r  <= 1'b0;
      nrx_meta_r <= 1'b0;
      nrx_sync_r <= 1'b0;
    end else begin
      rx_meta_r  <= RXin;
      rx_sync_r  <= rx_meta_r;
      nrx_meta_r <= nRXin;
      nrx_sync_r <= nrx_meta_r;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; CHECK chains straight into SYNC1 so back-to-back words lose no sync sample
  always_comb begin
    state_nxt_s = state_r;
    if (!grant) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (valid_s) state_nxt_s = ST_SYNC1;
          else         state_nxt_s = ST_IDLE;
        end
        ST_SYNC1: begin
          if (!valid_s)           state_nxt_s = ST_IDLE;
          else if (sync_same_s)   state_nxt_s = (cnt_r >= SYNC_MAX) ? ST_IDLE : ST_SYNC1;
          else if (run_in_win_s)  state_nxt_s = ST_SYNC2;
          else                    state_nxt_s = ST_IDLE;
        end
        ST_SYNC2: begin
          // Second half cannot be timed by its trailing edge: a leading 0 bit extends the run.
          if (!valid_s)           state_nxt_s = ST_IDLE;
          else if (!sync_same_s)  state_nxt_s = (cnt_r >= SYNC_NOM_M1) ? ST_BITS : ST_SYNC2;
          else if (cnt_r >= SYNC_MIN) state_nxt_s = ST_BITS;
          else                    state_nxt_s = ST_IDLE;
        end
        ST_BITS: begin
          if (bits_err_s) state_nxt_s = ST_IDLE;
          else if ((ph_r == BIT_LAST) && (bit_idx_r == LAST_IDX)) state_nxt_s = ST_CHECK;
          else            state_nxt_s = ST_BITS;
        end
        ST_CHECK: begin
          if (valid_s) state_nxt_s = ST_SYNC1;
          else         state_nxt_s = ST_IDLE;
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Output decode: push requests and busy, registered below
  always_comb begin
    busy_s = (state_nxt_s != ST_IDLE);
    if (grant && (state_r == ST_CHECK)) begin
      push_good_s = parity_ok_s;
      push_err_s  = ERR_PUSH_EN & !parity_ok_s;
    end else if (grant && (state_r == ST_BITS)) begin
      push_good_s = 1'b0;
      push_err_s  = ERR_PUSH_EN & bits_err_s;
    end else begin
      push_good_s = 1'b0;
      push_err_s  = 1'b0;
    end
  end

  // Run-length counting, half-bit sampling and bit assembly
  always_ff @(posedge clk) begin
    if (!nRst) begin
      lvl_q_r    <= 1'b0;
      sync_lvl_r <= 1'b0;
      cnt_r      <= 8'd0;
      ph_r       <= 7'd0;
      bit_idx_r  <= 5'd0;
      half1_r    <= 1'b0;
      word_r     <= 16'd0;
      par_r      <= 1'b0;
    end else begin
      lvl_q_r <= lvl_s;
      case (state_r)
        ST_IDLE, ST_CHECK: begin
          cnt_r      <= 8'd1;
          sync_lvl_r <= lvl_s;
        end
        ST_SYNC1: begin
          cnt_r <= sync_same_s ? (cnt_r + 8'd1) : 8'd1;
        end
        ST_SYNC2: begin
          cnt_r     <= cnt_r + 8'd1;
          ph_r      <= sync_same_s ? 7'd1 : 7'd0;
          bit_idx_r <= 5'd0;
          half1_r   <= 1'b0;
          word_r    <= 16'd0;
          par_r     <= 1'b0;
        end
        ST_BITS: begin
          // Mid-bit transitions realign the bit phase to absorb clock drift.
          if (edge_s && (ph_r >= MID_LO) && (ph_r <= MID_HI)) ph_r <= MID_NEXT;
          else if (ph_r == BIT_LAST)                          ph_r <= 7'd0;
          else                                                ph_r <= ph_r + 7'd1;
          if (ph_r == SAMP1) half1_r <= lvl_s;
          if (ph_r == SAMP2) begin
            if (bit_idx_r < 5'd16) word_r[4'd15 - bit_idx_r[3:0]] <= half1_r;
            else                   par_r <= half1_r;
            bit_idx_r <= bit_idx_r + 5'd1;
          end
        end
        default: cnt_r <= 8'd0;
      endcase
    end
  end

  // Registered push bus and busy flag; type/word hold until the next push
  always_ff @(posedge clk) begin
    if (!nRst) begin
      req_r   <= 1'b0;
      busy_r  <= 1'b0;
      type_r  <= 2'd0;
      dword_r <= 16'd0;
    end else begin
      busy_r <= busy_s;
      req_r  <= push_good_s | push_err_s;
      if (push_good_s | push_err_s) begin
        type_r  <= push_err_s ? WERROR : (sync_lvl_r ? WCOMMAND : WDATA);
        dword_r <= word_r;
      end
    end
  end

  assign busy               = busy_r;
  assign push.push_request  = req_r;
  assign push.push_dataType = type_r;
  assign push.push_dataWord = dword_r;

endmodule

// File: tb/tb_mil_receiver.sv
// Scoreboard bench for mil_receiver: a Manchester transmitter model drives the line and queues
// the expected pushes; an independent monitor pops and compares on every push strobe.
module tb_mil_receiver;
  localparam logic [1:0] WCOMMAND = 2'd0;
  localparam logic [1:0] WDATA    = 2'd2;
  localparam logic [1:0] WERROR   = 2'd3;

  logic clk   = 1'b0;
  logic nRst  = 1'b0;
  logic RXin  = 1'b0;
  logic nRXin = 1'b0;
  logic grant = 1'b0;
  logic busy;

  mil_receiver_if mil_if ();

  mil_receiver dut (
    .clk   (clk),
    .nRst  (nRst),
    .RXin  (RXin),
    .nRXin (nRXin),
    .grant (grant),
    .busy  (busy),
    .push  (mil_if)
  );

  always #10 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [17:0] exp_q[$];
  logic        prev_req  = 1'b0;
  logic        busy_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    RXin  = lvl;
    nRXin = ~lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    RXin  = 1'b0;
    nRXin = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    drive(b, 25);
    drive(~b, 25);
  endtask

  // null_at >= 0 replaces that bit position with one bit time of null and ends the word
  task automatic send_word(input logic sync_hi, input logic [15:0] data, input logic flip_par,
                           input int sync1_len, input int null_at);
    logic p;
    p = (~^data) ^ flip_par;
    drive(sync_hi, sync1_len);
    drive(~sync_hi, 75);
    for (int j = 0; j < 17; j++) begin
      if (j == null_at) begin
        RXin  = 1'b1;
        nRXin = 1'b1;
        repeat (50) @(negedge clk);
        return;
      end
      send_bit((j < 16) ? data[15 - j] : p);
    end
  endtask

  // Monitor: pops the scoreboard on every strobe, flags unexpected or stretched strobes
  always @(negedge clk) begin
    logic [17:0] e;
    if (busy === 1'b1) busy_seen = 1'b1;
    if (mil_if.push_request === 1'b1) begin
      check("strobe_one_cycle", {31'd0, prev_req}, 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_push: got type %0d word %h expected no push",
                 mil_if.push_dataType, mil_if.push_dataWord);
      end else begin
        e = exp_q.pop_front();
        check("push_type", {30'd0, mil_if.push_dataType}, {30'd0, e[17:16]});
        check("push_word", {16'd0, mil_if.push_dataWord}, {16'd0, e[15:0]});
      end
    end
    prev_req = mil_if.push_request;
  end

  initial begin
    @(negedge clk);
    idle(5);
    check("rst_req",  {31'd0, mil_if.push_request}, 32'd0);
    check("rst_type", {30'd0, mil_if.push_dataType}, 32'd0);
    check("rst_word", {16'd0, mil_if.push_dataWord}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    nRst = 1'b1;
    idle(20);

    // grant low: a valid word produces nothing
    busy_seen = 1'b0;
    send_word(1'b1, 16'hEFAB, 1'b0, 75, -1);
    idle(20);
    check("nogrant_busy", {31'd0, busy_seen}, 32'd0);
    check("nogrant_drained", exp_q.size(), 32'd0);

    grant = 1'b1;
    idle(100);

    // back-to-back command then data word
    exp_q.push_back({WCOMMAND, 16'hEFAB});
    exp_q.push_back({WDATA, 16'h02A1});
    busy_seen = 1'b0;
    send_word(1'b1, 16'hEFAB, 1'b0, 75, -1);
    send_word(1'b0, 16'h02A1, 1'b0, 75, -1);
    idle(20);
    check("b2b_busy_seen", {31'd0, busy_seen}, 32'd1);
    check("b2b_busy_idle", {31'd0, busy}, 32'd0);
    check("b2b_drained", exp_q.size(), 32'd0);

    // flipped parity bit
`ifdef MIL_RX_ERROR_PUSH_EN
    exp_q.push_back({WERROR, 16'h1234});
`endif
    send_word(1'b0, 16'h1234, 1'b1, 75, -1);
    idle(20);
    check("parity_drained", exp_q.size(), 32'd0);

    // 2.0 us first sync half is rejected
    send_word(1'b1, 16'h1234, 1'b0, 100, -1);
    idle(20);
    check("longsync_busy", {31'd0, busy}, 32'd0);
    check("longsync_drained", exp_q.size(), 32'd0);

    // reset mid-word, then a clean data word
    fork
      send_word(1'b1, 16'hBEEF, 1'b0, 75, -1);
      begin
        repeat (75 + 75 + 5 * 50) @(negedge clk);
        nRst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_req",  {31'd0, mil_if.push_request}, 32'd0);
        check("midrst_type", {30'd0, mil_if.push_dataType}, 32'd0);
        check("midrst_word", {16'd0, mil_if.push_dataWord}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        nRst = 1'b1;
      end
    join
    idle(50);
    exp_q.push_back({WDATA, 16'h0000});
    send_word(1'b0, 16'h0000, 1'b0, 75, -1);
    idle(20);
    check("midrst_drained", exp_q.size(), 32'd0);

    // null for one bit time after six bits aborts the word
`ifdef MIL_RX_ERROR_PUSH_EN
    exp_q.push_back({WERROR, 16'hC000});
`endif
    send_word(1'b0, 16'hC3A5, 1'b0, 75, 6);
    check("abort_busy", {31'd0, busy}, 32'd0);
    idle(30);
    exp_q.push_back({WCOMMAND, 16'h5A5A});
    send_word(1'b1, 16'h5A5A, 1'b0, 75, -1);
    idle(20);
    check("abort_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
